// File: rtl/toggle_hs_pkg.sv
// Shared definitions for the two-phase toggle handshake (receiver now,
// matching transmitter later).
//   rx_state_t       : receiver FSM states.
//   DEF_W            : default data width.
//   DEF_SYNC_STAGES  : default synchroniser depth on the incoming toggle.
//   DEF_CNT_W        : default width of the transfer counter.
package toggle_hs_pkg;

  typedef enum logic {IDLE, FULL} rx_state_t;

  localparam int DEF_W           = 8;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_CNT_W       = 8;

endpackage

// File: rtl/toggle_sync.sv
// Toggle synchroniser and flip detector. Resynchronises a level toggle and
// emits a single-cycle pulse for every change of the synchronised level.
//   clk    : clock
//   rst    : synchronous active-high reset
//   tgl_in : asynchronous toggle level
//   flip   : one-cycle pulse per toggle of tgl_in (after synchronisation)
module toggle_sync #(
  parameter int SYNC_STAGES = 2  // legal range 1..4
) (
  input  logic clk,
  input  logic rst,
  input  logic tgl_in,
  output logic flip
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= '0;
      r_last <= 1'b0;
    end else begin
      r_sync[0] <= tgl_in;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      // Tracks the synchronised level every cycle, so each toggle yields
      // exactly one cycle of mismatch.
      r_last <= r_sync[SYNC_STAGES-1];
    end
  end

  assign flip = r_sync[SYNC_STAGES-1] ^ r_last;

endmodule

// File: rtl/t_toggle_rx.sv
// Toggle-handshake receiver: detects each req_t flip, captures din, offers
// it downstream via valid/ready, and acknowledges by flipping ack_t once
// the consumer has taken the word.
//   clk, rst     : clock, synchronous active-high reset
//   req_t, din   : sender toggle and data (din stable until ack_t flips)
//   ack_t        : acknowledge toggle back to the sender
//   dout, dout_valid, dout_ready : downstream valid/ready handshake
//   overrun      : sticky flag, a flip arrived while a word was pending
//   clr_overrun  : clears overrun (a simultaneous new violation wins)
//   xfer_cnt     : wrapping count of consumed transfers
module t_toggle_rx
  import toggle_hs_pkg::*;
#(
  parameter int W           = DEF_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_t,
  input  logic [W-1:0]     din,
  output logic             ack_t,
  output logic [W-1:0]     dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             overrun,
  input  logic             clr_overrun,
  output logic [CNT_W-1:0] xfer_cnt
);

  rx_state_t        r_state, w_state_n;
  logic             w_flip;
  logic             w_capture, w_release, w_ovr_set;
  logic             r_ack;
  logic [W-1:0]     r_dout;
  logic             r_valid;
  logic             r_ovr;
  logic [CNT_W-1:0] r_cnt;

  toggle_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk    (clk),
    .rst    (rst),
    .tgl_in (req_t),
    .flip   (w_flip)
  );

  always_comb begin
    w_state_n = r_state;
    w_capture = 1'b0;
    w_release = 1'b0;
    w_ovr_set = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_flip) begin
          w_capture = 1'b1;
          w_state_n = FULL;
        end
      end
      FULL: begin
        if (dout_ready) begin
          w_release = 1'b1;
          w_state_n = IDLE;
        end
        // A flip while holding a word is a sender violation; the new word
        // is dropped even if the current one leaves this same cycle.
        if (w_flip) w_ovr_set = 1'b1;
      end
      default: w_state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_ack   <= 1'b0;
      r_dout  <= '0;
      r_valid <= 1'b0;
      r_ovr   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_n;
      if (w_capture) begin
        r_dout  <= din;
        r_valid <= 1'b1;
      end
      if (w_release) begin
        r_valid <= 1'b0;
        r_ack   <= ~r_ack;
        r_cnt   <= r_cnt + CNT_W'(1);
      end
      if (w_ovr_set)        r_ovr <= 1'b1;
      else if (clr_overrun) r_ovr <= 1'b0;
    end
  end

  assign ack_t      = r_ack;
  assign dout       = r_dout;
  assign dout_valid = r_valid;
  assign overrun    = r_ovr;
  assign xfer_cnt   = r_cnt;

endmodule

// File: doc/t_toggle_rx.md
# t_toggle_rx

Receiving end of the two-phase toggle handshake, in which a sender drives a level `req_t` built around a T flip-flop: each transfer flips `req_t` once, with `din` held stable. This block synchronises `req_t` and detects each flip as one transfer. It captures `din`, presents the word downstream with a valid/ready handshake, and returns completion by flipping its own `ack_t` level. It sits between a toggle-based sender and any valid/ready consumer in the same clock-enable style design.

## Interface
- `W`, 8: data width.
- `SYNC_STAGES`, 2: synchroniser depth on `req_t`, legal range 1..4.
- `CNT_W`, 8: width of accepted-transfer counter.

- `clk`  in  1  rising-edge clock; the only clock.
- `rst`  in  1  reset, synchronous, active-high.
- `req_t`  in  1  request toggle from sender; one flip = one transfer.
- `din`  in  W  sender data; stable from `req_t` flip until matching `ack_t` flip.
- `ack_t`  out  1  acknowledge toggle back to sender.
- `dout`  out  W  captured word.
- `dout_valid`  out  1  `dout` holds an unconsumed word.
- `dout_ready`  in  1  consumer accepts when high with `dout_valid`.
- `overrun`  out  1  sticky protocol-violation flag.
- `clr_overrun`  in  1  clears `overrun`.
- `xfer_cnt`  out  CNT_W  count of accepted (consumed) transfers; wraps.

## Operation
- Reset values:
  - `ack_t`=0, `dout`=0, `dout_valid`=0, `overrun`=0, `xfer_cnt`=0.
  - All synchroniser flops and the last-seen-request register are 0.
  - The FSM enters IDLE.
  - The sender's toggle also resets to 0.
- Toggle detect: `flip` = (synchronised `req_t`) XOR (last-seen register). The last-seen register updates to the synchronised value every cycle, so each flip produces exactly one single-cycle `flip`.
- FSM states: IDLE, FULL.
  - IDLE & `flip`: `dout`<=`din`, `dout_valid`<=1, go to FULL.
  - FULL & `dout_ready`: `dout_valid`<=0, `ack_t`<=~`ack_t`, `xfer_cnt`<=`xfer_cnt`+1 (mod 2^CNT_W), go to IDLE.
  - FULL & `flip` & no `dout_ready`: this is a sender violation. Set `overrun`<=1, drop the new word and do not acknowledge it; `dout` is unchanged.
  - FULL & `flip` & `dout_ready` in the same cycle: complete the current transfer as above, then drop the new word and set `overrun`. Never capture and release in one cycle.
- `overrun` is cleared only by `clr_overrun`. If `clr_overrun` and a new violation occur in the same cycle, set wins.
- `dout` changes only on capture; it holds its value after consumption.
- `rst` mid-transfer: a pending word is lost and `ack_t` returns to 0. A `req_t` flip that is in flight in the synchroniser is discarded.

## Timing
- Let `req_t` change before rising edge k.
  - Synchronised value is visible after edge k+SYNC_STAGES-1.
  - `flip` is high during the following cycle.
  - `dout`/`dout_valid` are updated after edge k+SYNC_STAGES.
  - Latency from the flip to `dout_valid` is SYNC_STAGES+1 edges (3 at the default).
- `ack_t` flips on the same edge that samples `dout_valid`&`dout_ready` high.
- Minimum sender cycle with `dout_ready` tied high is SYNC_STAGES+2 edges per transfer, plus the sender's own ack synchroniser.
- All outputs are registered; there is no combinational path from any input to any output.

## Structure
- Package `toggle_hs_pkg`:
  - `typedef enum logic {IDLE, FULL} rx_state_t`.
  - Default constants for `W`, `SYNC_STAGES`, `CNT_W`.
  - The package is shared with the future matching transmitter.
- Sub-module `toggle_sync`:
  - Parameter SYNC_STAGES.
  - Ports `clk`, `rst`, `tgl_in`, `flip`.
  - Contains the synchroniser chain, the last-seen register and the XOR.
  - It is reused on the transmitter's `ack_t` side.
- Top level `t_toggle_rx`: FSM, data register, `ack_t`, `overrun`, `xfer_cnt`.

## Test plan
- Reset, then single transfer:
  - Stimulus: `din`=8'hA5, flip `req_t` 0->1 before edge 1, `dout_ready`=1.
  - Required: `dout_valid` rises after edge 3 with `dout`=A5; it falls and `ack_t`=1 after edge 4; `xfer_cnt`=1.
- Backpressure:
  - Stimulus: `dout_ready`=0 for 10 cycles after capture of 8'h3C.
  - Required: `dout_valid` and `dout`=3C are held and `ack_t` is stable; both change on the first edge with `dout_ready`=1.
- Overrun:
  - Stimulus: flip `req_t` twice (din 11 then 22) while `dout_ready`=0.
  - Required: `overrun`=1 and `dout` stays 11; after consume, `ack_t` has flipped once and `xfer_cnt`+=1.
  - Follow-up: `clr_overrun` pulse -> `overrun`=0.
- Counter wrap:
  - Stimulus: CNT_W=2, run 5 back-to-back transfers.
  - Required: `xfer_cnt` sequence 1,2,3,0,1; `ack_t` ends at 1.
- Reset mid-operation:
  - Stimulus: assert `rst` while FULL, and separately one cycle after a `req_t` flip.
  - Required: all outputs return to reset values next edge, and no spurious `dout_valid` follows deassertion.
- SYNC_STAGES=1 and 4:
  - Required: flip-to-`dout_valid` latency is 2 and 5 edges respectively.
